// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - in-place radix-2 DIT FFT butterfly address sequencer with write-back pipeline
// Optional issue stall input is enabled by defining FFT_CTRL_STALL_EN.
module fft_ctrl #(
    parameter int LOG2N  = 3,
    parameter int WB_LAT = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
`ifdef FFT_CTRL_STALL_EN
    input  logic                     stall_i,
`endif
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(LOG2N)-1:0] stage_o,
    output logic                     rd_en_o,
    output logic [LOG2N-1:0]         rd_a_addr_o,
    output logic [LOG2N-1:0]         rd_b_addr_o,
    output logic [LOG2N-2:0]         tw_addr_o,
    output logic                     wr_en_o,
    output logic [LOG2N-1:0]         wr_a_addr_o,
    output logic [LOG2N-1:0]         wr_b_addr_o
);

    localparam int SW = $clog2(LOG2N);
    localparam int CW = $clog2(WB_LAT + 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [CW-1:0] D_LAST = CW'(WB_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [LOG2N-2:0] k, k_n;
    logic [SW-1:0]    s, s_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             stall;
    logic             issue;

`ifdef FFT_CTRL_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            s     <= s_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        s_n     = s;
        cnt_n   = cnt;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = RUN;
                    k_n     = '0;
                    s_n     = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    // k is all ones on the last butterfly of a stage (k_max = N/2-1)
                    if (&k) begin
                        state_n = DRAIN;
                        k_n     = '0;
                        cnt_n   = '0;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cnt == D_LAST) begin
                    cnt_n = '0;
                    if (s != S_LAST) begin
                        s_n     = s + 1'b1;
                        state_n = RUN;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // span = 1<<s; a keeps the low s bits of k and inserts a zero at bit s
    logic [LOG2N-1:0] kx, span, pos, grp, a_c, b_c;
    logic [LOG2N-2:0] tw_c;

    always_comb begin
        kx   = {1'b0, k};
        span = LOG2N'(1) << s;
        pos  = kx & (span - LOG2N'(1));
        grp  = kx >> s;
        a_c  = ((grp << s) << 1) | pos;
        b_c  = a_c | span;
        tw_c = (LOG2N-1)'(pos << (LOG2N - 1 - int'(s)));
    end

    logic [LOG2N-1:0] last_a, last_b;
    logic [LOG2N-2:0] last_tw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_a  <= '0;
            last_b  <= '0;
            last_tw <= '0;
        end else if (issue) begin
            last_a  <= a_c;
            last_b  <= b_c;
            last_tw <= tw_c;
        end
    end

    assign rd_en_o     = issue;
    assign rd_a_addr_o = issue ? a_c  : last_a;
    assign rd_b_addr_o = issue ? b_c  : last_b;
    assign tw_addr_o   = issue ? tw_c : last_tw;

    // Free-running write-back delay line; reset drops any in-flight writes
    logic             pv [WB_LAT];
    logic [LOG2N-1:0] pa [WB_LAT];
    logic [LOG2N-1:0] pb [WB_LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < WB_LAT; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
                pb[i] <= '0;
            end
        end else begin
            pv[0] <= issue;
            pa[0] <= rd_a_addr_o;
            pb[0] <= rd_b_addr_o;
            for (int i = 1; i < WB_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    assign wr_en_o     = pv[WB_LAT-1];
    assign wr_a_addr_o = pa[WB_LAT-1];
    assign wr_b_addr_o = pb[WB_LAT-1];

    assign busy_o  = (state == RUN) || (state == DRAIN);
    assign done_o  = (state == DONE);
    assign stage_o = s;

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

In-place radix-2 DIT FFT sequencer for an N-point transform (N = 2^LOG2N) held in a dual-port data RAM. It issues one butterfly per cycle by driving the RAM read addresses and the twiddle ROM address, then returns each result to the same two addresses after a fixed pipeline latency. It also inserts a drain gap between stages so no read overtakes a pending write. Upstream loads the data RAM in bit-reversed order; the butterfly datapath, including its per-stage 1-bit right shift, sits between the RAM read ports and the write ports.

## Interface
- LOG2N, default 3: log2 of transform length; minimum 2.
- WB_LAT, default 2: cycles from read issue to write-back (RAM/ROM read 1 + output register 1); minimum 1.
- clk_i  in  1  sole clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- start_i  in  1  start a transform; sampled only in IDLE.
- stall_i  in  1  freeze issue (present only with FFT_CTRL_STALL_EN).
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse after the final write.
- stage_o  out  $clog2(LOG2N)  current stage index s.
- rd_en_o  out  1  butterfly issued this cycle.
- rd_a_addr_o, rd_b_addr_o  out  LOG2N each  read addresses of the issued butterfly.
- tw_addr_o  out  LOG2N-1  twiddle ROM index; N/2 entries.
- wr_en_o  out  1  write-back strobe.
- wr_a_addr_o, wr_b_addr_o  out  LOG2N each  write-back addresses.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start_i; k=0, s=0.
- RUN: issue butterfly k each cycle. After k=N/2-1, go to DRAIN and set k=0.
- DRAIN: runs for exactly WB_LAT cycles. Then, if s<LOG2N-1, increment s and return to RUN; otherwise go to DONE.
- DONE: lasts one cycle, then returns to IDLE.
- Address generation, with span=1<<s, pos=k&(span-1), grp=k>>s:
  - a = grp*2*span + pos
  - b = a + span
  - tw = pos << (LOG2N-1-s)
- Write-back is a WB_LAT-deep shift register of {valid, a, b}. It advances every cycle regardless of state, so wr_en_o equals rd_en_o delayed by WB_LAT with matching addresses.
- start_i is ignored outside IDLE; a start during DONE is not latched.
- When rd_en_o=0, the rd_*/tw outputs hold their last values; consumers must gate on rd_en_o.

## Timing
- Reset values:
  - state IDLE; k=0, s=0; pipeline valid bits cleared.
  - busy_o, done_o, rd_en_o and wr_en_o are 0.
  - stage_o, all address outputs and tw_addr_o are 0.
- Reset mid-transform drops every in-flight write: no wr_en_o appears after reset.
- start_i high at cycle 0: the first rd_en_o is at cycle 1, and its write is at cycle 1+WB_LAT.
- busy_o stays high for exactly LOG2N*(N/2+WB_LAT) cycles. done_o is high on the next cycle.
- For N=8 and WB_LAT=2: busy_o covers cycles 1–18, the last wr_en_o is at cycle 18, and done_o is at cycle 19.
- A stage's final write lands on the last DRAIN cycle. The next stage's first read is one cycle later, so there is no read-after-write hazard.

## Configuration
- FFT_CTRL_STALL_EN defined:
  - stall_i port exists.
  - stall_i=1 in RUN forces rd_en_o=0 and holds k and s.
  - The write pipeline and the DRAIN counter keep advancing during a stall.
  - stall_i has no effect in IDLE, DRAIN or DONE.
- FFT_CTRL_STALL_EN undefined: no stall_i port; behaviour is identical to stall_i tied to 0.

## Test plan
- N=8, pulse start_i at cycle 0 -> rd_en_o is high on cycles 1–4, 7–10 and 13–16, with (a,b,tw) as follows:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- Same run -> each wr_en_o/address set equals the rd set delayed by exactly 2 cycles; busy_o high on cycles 1–18; done_o only on cycle 19; stage_o values 0, 1, 2.
- start_i held high for the entire run -> a second transform begins only after returning to IDLE (first rd_en_o at cycle 21). Repeated pulses during busy_o are ignored.
- rst_i asserted at cycle 9 -> from cycle 10 all outputs are 0, no wr_en_o appears, and a new start_i begins cleanly at stage 0.
- With FFT_CTRL_STALL_EN, stall_i high on cycles 2–3 -> stage 0 issues on cycles 1, 4, 5, 6 and the writes on cycles 3, 6, 7, 8 are unaffected. Total busy is extended by 2 cycles.
- LOG2N=4, WB_LAT=1 -> 32 butterflies in 4 stages; busy_o lasts 36 cycles; butterfly k=5 in stage 2 gives (a,b,tw)=(9,13,2).
